// File: rtl/pipe_pkg.sv
// Shared constants for the OpenMIPS inter-stage pipeline registers:
// stall encoding, default widths and the ex/mem payload and context layouts.
package pipe_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int STALL_W_DEF = 6;

    localparam logic [4:0] NOP_REG_ADDR = 5'd0;

    // ex/mem payload packing, MSB first: wd, wreg, wdata, hi, lo, whilo
    localparam int PL_WHILO_BIT = 0;
    localparam int PL_LO_LSB    = 1;
    localparam int PL_HI_LSB    = 33;
    localparam int PL_WDATA_LSB = 65;
    localparam int PL_WREG_BIT  = 97;
    localparam int PL_WD_LSB    = 98;
    localparam int PL_W         = 103;

    localparam int CTX_CNT_LSB  = 0;
    localparam int CTX_CNT_W    = 2;
    localparam int CTX_HILO_LSB = 2;
    localparam int CTX_HILO_W   = 64;
    localparam int CTX_W_DEF    = CTX_HILO_W + CTX_CNT_W;

endpackage

// File: rtl/sat_counter.sv
// Synchronous up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: payload + valid, stall/flush handling,
// multicycle context save and saturating stall/bubble counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = PL_W,
    parameter logic [DATA_W-1:0] NOP_PAYLOAD = '0,
    parameter int                CTX_W       = CTX_W_DEF,
    parameter int                STALL_W     = STALL_W_DEF,
    parameter int                STAGE       = 3,
    parameter int                PERF_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_payload,
    input  logic [CTX_W-1:0]   ctx_i,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_payload,
    output logic [CTX_W-1:0]   ctx_o,
    output logic               ctx_valid_o,
    output logic [PERF_W-1:0]  stall_cnt_o,
    output logic [PERF_W-1:0]  bubble_cnt_o
);

    // The last stage has no downstream stall bit, so it can never hold.
    localparam bit HAS_DN = (STAGE < STALL_W - 1);
    localparam int DN_IDX = HAS_DN ? STAGE + 1 : STAGE;

    logic up_stop;
    logic dn_stop;
    logic do_bubble;
    logic do_hold;

    logic              valid_q,     valid_d;
    logic [DATA_W-1:0] payload_q,   payload_d;
    logic [CTX_W-1:0]  ctx_q,       ctx_d;
    logic              ctx_valid_q, ctx_valid_d;

    assign up_stop   = (stall[STAGE] == STOP);
    assign dn_stop   = HAS_DN ? (stall[DN_IDX] == STOP) : NO_STOP;
    assign do_bubble = !flush && up_stop && !dn_stop;
    assign do_hold   = !flush && up_stop && dn_stop;

    always_comb begin
        valid_d     = valid_q;
        payload_d   = payload_q;
        ctx_d       = '0;
        ctx_valid_d = 1'b0;
        if (flush) begin
            valid_d   = 1'b0;
            payload_d = NOP_PAYLOAD;
        end else if (do_bubble) begin
            valid_d     = 1'b0;
            payload_d   = NOP_PAYLOAD;
            ctx_d       = ctx_i;
            ctx_valid_d = 1'b1;
        end else if (!up_stop) begin
            valid_d   = in_valid;
            payload_d = in_payload;
        end else begin
            // Downstream stalled too: keep the slot, keep tracking upstream context.
            ctx_d       = ctx_i;
            ctx_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            payload_q   <= NOP_PAYLOAD;
            ctx_q       <= '0;
            ctx_valid_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            payload_q   <= payload_d;
            ctx_q       <= ctx_d;
            ctx_valid_q <= ctx_valid_d;
        end
    end

    // A stalled downstream with a running upstream means the stall vector is broken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (up_stop || !dn_stop)
                else $warning("pipe_stage_reg: non-monotone stall vector %b", stall);
        end
    end

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (do_hold),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(PERF_W)) u_bubble_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (do_bubble),
        .cnt_o (bubble_cnt_o)
    );

    assign out_valid   = valid_q;
    assign out_payload = payload_q;
    assign ctx_o       = ctx_q;
    assign ctx_valid_o = ctx_valid_q;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic parametrised inter-stage pipeline register for the OpenMIPS core.
- Replaces the per-stage hand-written registers (if/id, id/ex, ex/mem, mem/wb) with one block.
- Carries a packed payload plus valid bit and honours the global stall vector.
- Adds a synchronous flush for exception/branch squash, a multicycle context save path (HI/LO accumulator plus cycle counter for madd/msub-class ops), and saturating stall/bubble performance counters.

Parameters:
- DATA_W, 103, payload width (default ex/mem packing: wd 5, wreg 1, wdata 32, hi 32, lo 32, whilo 1).
- NOP_PAYLOAD, 103'b0, payload value driven on reset, bubble and flush.
- CTX_W, 66, multicycle context width (hilo 64 + cnt 2).
- STALL_W, 6, stall vector width.
- STAGE, 3, index of this register's upstream stage in the stall vector. Legal range 0..STALL_W-1.
- PERF_W, 16, width of each performance counter.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, synchronous, active-high reset.
- stall, in, STALL_W, global stall vector; bit = 1 means stop.
- flush, in, 1, synchronous squash of this register.
- in_valid, in, 1, upstream slot holds a real instruction.
- in_payload, in, DATA_W, upstream payload.
- ctx_i, in, CTX_W, multicycle context produced by the upstream stage.
- out_valid, out, 1, registered valid.
- out_payload, out, DATA_W, registered payload.
- ctx_o, out, CTX_W, saved context, fed back to the upstream stage.
- ctx_valid_o, out, 1, ctx_o holds a saved context.
- stall_cnt_o, out, PERF_W, cycles spent in hold.
- bubble_cnt_o, out, PERF_W, bubbles inserted.

Behaviour:
- Definitions:
  - up_stop = stall[STAGE].
  - dn_stop = stall[STAGE+1]; forced to 0 when STAGE == STALL_W-1.
- Action priority, evaluated each rising edge, highest first:
  1. rst: out_valid = 0, out_payload = NOP_PAYLOAD, ctx_o = 0, ctx_valid_o = 0, both counters = 0.
  2. flush: out_valid = 0, out_payload = NOP_PAYLOAD, ctx_o = 0, ctx_valid_o = 0. Counters unchanged. Flush overrides any stall combination and discards any in-progress multicycle context.
  3. BUBBLE (up_stop = 1, dn_stop = 0): out_valid = 0, out_payload = NOP_PAYLOAD, ctx_o = ctx_i, ctx_valid_o = 1. bubble_cnt_o increments, saturating at all-ones.
  4. ADVANCE (up_stop = 0): out_valid = in_valid, out_payload = in_payload, ctx_o = 0, ctx_valid_o = 0.
  5. HOLD (up_stop = 1, dn_stop = 1): out_valid and out_payload keep their values. ctx_o = ctx_i and ctx_valid_o = 1, so context keeps tracking upstream during a downstream stall. stall_cnt_o increments, saturating.
- Latency: one cycle from in_* to out_* on ADVANCE. No combinational path from any input to any output.
- Illegal pattern up_stop = 0 with dn_stop = 1 (stall not monotone): treated as ADVANCE. Flag it with an assertion in simulation only.
- Counters wrap never; they hold at 2^PERF_W-1.
- Reset or flush during a multicycle sequence clears context. The upstream op restarts from cnt = 0.
- in_valid = 0 on ADVANCE passes in_payload through unchanged; consumers gate on out_valid.

Decomposition:
- Package pipe_pkg holds:
  - STOP / NO_STOP constants and the STALL_W default.
  - NOP register address.
  - Payload field offsets for the ex/mem packing.
  - CTX field offsets: hilo at [65:2], cnt at [1:0].
- Sub-module sat_counter (width param, inc, clr; synchronous). Instantiated twice for the perf counters.

Test Plan:
- Reset: assert rst 2 cycles with payload 103'h1234 and stall 0 -> out_valid = 0, out_payload = 0, ctx_valid_o = 0, both counters = 0.
- Advance: stall = 6'b000000, in_valid = 1, payload = P1 -> next cycle out_payload = P1, out_valid = 1, ctx_valid_o = 0.
- Bubble with context: stall = 6'b001111, ctx_i = {64'hA5A5_0000_0000_0001, 2'b01} -> out_valid = 0, out_payload = NOP, ctx_o = ctx_i, ctx_valid_o = 1, bubble_cnt_o = 1. Then stall = 0 with payload P2 -> out = P2, ctx cleared.
- Hold: load P3, then stall = 6'b011111 for 4 cycles -> out_payload stays P3, stall_cnt_o = 4, ctx_o tracks ctx_i each cycle.
- Flush priority: stall = 6'b001111 with flush = 1 and ctx_i nonzero -> out_valid = 0, ctx_valid_o = 0, bubble_cnt_o unchanged.
- Saturation / last stage: PERF_W = 2 and 5 bubble cycles -> bubble_cnt_o = 3. STAGE = 5 with stall[5] = 1 -> BUBBLE, not HOLD.
